// File: rtl/core_config_pkg.sv
// ============================================================================
// core_config_pkg : core-wide configuration constants
// Rev 1.0
// ============================================================================
`default_nettype none

package core_config_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int N_ALU      = 5;
   localparam int ALU_IDX_W  = $clog2(N_ALU);

endpackage : core_config_pkg

`default_nettype wire

// File: rtl/alu_commit_arbiter_rr.sv
// ============================================================================
// rr_arbiter : round-robin arbiter with internal pointer, one-hot grant + index
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_i,
   input  logic             enable_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic             found;

   // Search starts at the pointer and wraps; the pointer is always < N.
   always_comb begin
      int j;
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         if (enable_i && !found && req_i[j]) begin
            found     = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_idx_o = IDX_W'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/alu_commit_arbiter.sv
// ============================================================================
// alu_commit_arbiter : round-robin share of the RF write port among the ALUs
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_commit_arbiter
   import core_config_pkg::*;
#(
   parameter int N_ALU      = core_config_pkg::N_ALU,
   parameter int XLEN       = core_config_pkg::XLEN,
   parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_ALU*XLEN-1:0]         alu_res,
   input  logic [N_ALU*REG_ADDR_W-1:0]   alu_rd,
   input  logic [N_ALU-1:0]              alu_valid,
   input  logic [N_ALU-1:0]              alu_error,
   input  logic [N_ALU-1:0]              alu_req,
   output logic [N_ALU-1:0]              alu_clear,
   output logic                          wb_en,
   output logic [REG_ADDR_W-1:0]         wb_rd,
   output logic [XLEN-1:0]               wb_data,
   input  logic                          wb_ready,
   output logic                          exc_valid,
   output logic [$clog2(N_ALU)-1:0]      exc_src,
   input  logic                          exc_ack,
   input  logic                          flush
);

   localparam int IDX_W = $clog2(N_ALU);

   logic                  stg_full_q, stg_full_d;
   logic                  stg_err_q,  stg_err_d;
   logic [IDX_W-1:0]      stg_src_q,  stg_src_d;
   logic [REG_ADDR_W-1:0] stg_rd_q,   stg_rd_d;
   logic [XLEN-1:0]       stg_data_q, stg_data_d;

   logic [N_ALU-1:0] eligible;
   logic [N_ALU-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             drain;
   logic             can_load;
   logic             arb_en;

   assign eligible = alu_req & alu_valid;

   // An x0 entry has nothing to write, so it leaves without waiting on the port.
   assign drain = stg_full_q &
                  ((!stg_err_q & (wb_ready | (stg_rd_q == '0))) | (stg_err_q & exc_ack));
   assign can_load = !stg_full_q | drain;
   // Gating with rst_n keeps clear low while the core is held in reset.
   assign arb_en   = can_load & !flush & rst_n;

   rr_arbiter #(
      .N     (N_ALU),
      .IDX_W (IDX_W)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (eligible),
      .enable_i  (arb_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign alu_clear = gnt;

   always_comb begin
      stg_full_d = stg_full_q;
      stg_err_d  = stg_err_q;
      stg_src_d  = stg_src_q;
      stg_rd_d   = stg_rd_q;
      stg_data_d = stg_data_q;
      if (flush) begin
         stg_full_d = 1'b0;
      end else if (|gnt) begin
         stg_full_d = 1'b1;
         stg_err_d  = alu_error[gnt_idx];
         stg_src_d  = gnt_idx;
         stg_rd_d   = alu_rd[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
         stg_data_d = alu_res[gnt_idx*XLEN +: XLEN];
      end else if (drain) begin
         stg_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_full_q <= 1'b0;
         stg_err_q  <= 1'b0;
         stg_src_q  <= '0;
         stg_rd_q   <= '0;
         stg_data_q <= '0;
      end else begin
         stg_full_q <= stg_full_d;
         stg_err_q  <= stg_err_d;
         stg_src_q  <= stg_src_d;
         stg_rd_q   <= stg_rd_d;
         stg_data_q <= stg_data_d;
      end
   end

   assign wb_en     = stg_full_q & !stg_err_q & (stg_rd_q != '0);
   assign wb_rd     = stg_rd_q;
   assign wb_data   = stg_data_q;
   assign exc_valid = stg_full_q & stg_err_q;
   assign exc_src   = stg_src_q;

endmodule : alu_commit_arbiter

`default_nettype wire

// File: tb/tb_alu_commit_arbiter.sv
// ============================================================================
// tb_alu_commit_arbiter : directed self-checking bench for alu_commit_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_commit_arbiter;

   localparam int N  = 5;
   localparam int XL = 32;
   localparam int RW = 5;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N-1:0][XL-1:0] res;
   logic [N-1:0][RW-1:0] rd;
   logic [N-1:0]        valid, err, req;
   logic [N-1:0]        alu_clear;
   logic                wb_en, wb_ready, exc_valid, exc_ack, flush;
   logic [RW-1:0]       wb_rd;
   logic [XL-1:0]       wb_data;
   logic [2:0]          exc_src;

   int tests = 0;
   int fails = 0;

   alu_commit_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_res   (res),
      .alu_rd    (rd),
      .alu_valid (valid),
      .alu_error (err),
      .alu_req   (req),
      .alu_clear (alu_clear),
      .wb_en     (wb_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_ready  (wb_ready),
      .exc_valid (exc_valid),
      .exc_src   (exc_src),
      .exc_ack   (exc_ack),
      .flush     (flush)
   );

   always #5 clk = ~clk;

   // Inputs change 1 unit after the active edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      res = '0; rd = '0; valid = '0; err = '0; req = '0;
      wb_ready = 1'b0; exc_ack = 1'b0; flush = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      req = 5'b11111; valid = 5'b11111;
      tick();
      #1;
      tests++;
      if ({wb_en, exc_valid} !== 2'b00) begin
         fails++; $display("FAIL reset_en: got %b required 00", {wb_en, exc_valid});
      end
      tests++;
      if ({wb_rd, wb_data, exc_src} !== '0) begin
         fails++; $display("FAIL reset_fields: got rd=%0h data=%0h src=%0h required 0", wb_rd, wb_data, exc_src);
      end
      tests++;
      if (alu_clear !== 5'b00000) begin
         fails++; $display("FAIL reset_clear: got %b required 00000", alu_clear);
      end
      apply_reset();
   endtask

   task automatic test_single();
      apply_reset();
      req[2] = 1'b1; valid[2] = 1'b1; rd[2] = 5'd5; res[2] = 32'hDEADBEEF; wb_ready = 1'b1;
      #1;
      tests++;
      if (alu_clear !== 5'b00100) begin
         fails++; $display("FAIL single_clear: got %b required 00100", alu_clear);
      end
      tick();
      req[2] = 1'b0;
      #1;
      tests++;
      if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         fails++; $display("FAIL single_wb: got en=%b rd=%0d data=%h required 1 5 deadbeef", wb_en, wb_rd, wb_data);
      end
      tests++;
      if (dut.u_rr.ptr_q !== 3'd3) begin
         fails++; $display("FAIL single_ptr: got %0d required 3", dut.u_rr.ptr_q);
      end
      tick();
      tests++;
      if (wb_en !== 1'b0) begin
         fails++; $display("FAIL single_drain: got wb_en=%b required 0", wb_en);
      end
   endtask

   task automatic test_round_robin();
      int exp_idx;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         rd[i] = RW'(i + 10); res[i] = 32'hA000 + i;
      end
      req = 5'b11111; valid = 5'b11111; wb_ready = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         exp_idx = k % N;
         tests++;
         if (alu_clear !== 5'(1 << exp_idx)) begin
            fails++; $display("FAIL rr_clear_%0d: got %b required %b", k, alu_clear, 5'(1 << exp_idx));
         end
         tick();
         #1;
         tests++;
         if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'(exp_idx + 10), 32'hA000 + 32'(exp_idx)}) begin
            fails++; $display("FAIL rr_wb_%0d: got en=%b rd=%0d data=%h required 1 %0d %h",
                              k, wb_en, wb_rd, wb_data, exp_idx + 10, 32'hA000 + exp_idx);
         end
      end
      req = '0;
   endtask

   task automatic test_stall();
      apply_reset();
      req[1:0] = 2'b11; valid[1:0] = 2'b11; rd[0] = 5'd7; rd[1] = 5'd8;
      res[0] = 32'h1111_0000; res[1] = 32'h2222_0000;
      #1;
      tests++;
      if (alu_clear !== 5'b00001) begin
         fails++; $display("FAIL stall_first: got %b required 00001", alu_clear);
      end
      tick();
      req[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if ({alu_clear, wb_en, wb_rd} !== {5'b00000, 1'b1, 5'd7}) begin
            fails++; $display("FAIL stall_hold_%0d: got clear=%b en=%b rd=%0d required 00000 1 7", c, alu_clear, wb_en, wb_rd);
         end
         tick();
      end
      wb_ready = 1'b1;
      #1;
      tests++;
      if ({alu_clear, wb_rd} !== {5'b00010, 5'd7}) begin
         fails++; $display("FAIL stall_release: got clear=%b rd=%0d required 00010 7", alu_clear, wb_rd);
      end
      tick();
      req[1] = 1'b0;
      #1;
      tests++;
      if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd8, 32'h2222_0000}) begin
         fails++; $display("FAIL stall_second: got en=%b rd=%0d data=%h required 1 8 22220000", wb_en, wb_rd, wb_data);
      end
   endtask

   task automatic test_x0();
      apply_reset();
      req[3] = 1'b1; valid[3] = 1'b1; rd[3] = 5'd0; res[3] = 32'h5555;
      #1;
      tests++;
      if (alu_clear !== 5'b01000) begin
         fails++; $display("FAIL x0_clear: got %b required 01000", alu_clear);
      end
      tick();
      req[3] = 1'b0;
      #1;
      tests++;
      if ({dut.stg_full_q, wb_en} !== 2'b10) begin
         fails++; $display("FAIL x0_loaded: got full,en=%b required 10", {dut.stg_full_q, wb_en});
      end
      tick();
      #1;
      tests++;
      if ({dut.stg_full_q, wb_en} !== 2'b00) begin
         fails++; $display("FAIL x0_empty: got full,en=%b required 00", {dut.stg_full_q, wb_en});
      end
   endtask

   task automatic test_error_hold();
      apply_reset();
      wb_ready = 1'b1;
      req[3] = 1'b1; valid[3] = 1'b1; rd[3] = 5'd3;
      tick();
      req[3] = 1'b0;
      req[4] = 1'b1; valid[4] = 1'b1; err[4] = 1'b1; rd[4] = 5'd9;
      req[0] = 1'b1; valid[0] = 1'b1; rd[0] = 5'd12; res[0] = 32'hCAFE;
      #1;
      tests++;
      if (alu_clear !== 5'b10000) begin
         fails++; $display("FAIL err_grant4: got %b required 10000", alu_clear);
      end
      tick();
      req[4] = 1'b0; err[4] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests++;
         if ({exc_valid, exc_src, wb_en, alu_clear} !== {1'b1, 3'd4, 1'b0, 5'b00000}) begin
            fails++; $display("FAIL err_hold_%0d: got exc=%b src=%0d en=%b clear=%b required 1 4 0 00000",
                              c, exc_valid, exc_src, wb_en, alu_clear);
         end
         tick();
      end
      exc_ack = 1'b1;
      #1;
      tests++;
      if (alu_clear !== 5'b00001) begin
         fails++; $display("FAIL err_ack_grant: got %b required 00001", alu_clear);
      end
      tick();
      exc_ack = 1'b0; req[0] = 1'b0;
      #1;
      tests++;
      if ({exc_valid, wb_en, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd12, 32'hCAFE}) begin
         fails++; $display("FAIL err_after: got exc=%b en=%b rd=%0d data=%h required 0 1 12 cafe", exc_valid, wb_en, wb_rd, wb_data);
      end
   endtask

   task automatic test_flush_reset();
      apply_reset();
      req[0] = 1'b1; valid[0] = 1'b1; rd[0] = 5'd4;
      tick();
      req[0] = 1'b0;
      flush = 1'b1; wb_ready = 1'b1; req[1] = 1'b1; valid[1] = 1'b1; rd[1] = 5'd6;
      #1;
      tests++;
      if (alu_clear !== 5'b00000) begin
         fails++; $display("FAIL flush_clear: got %b required 00000", alu_clear);
      end
      tick();
      flush = 1'b0; req[1] = 1'b0;
      #1;
      tests++;
      if ({dut.stg_full_q, wb_en, dut.u_rr.ptr_q} !== {1'b0, 1'b0, 3'd1}) begin
         fails++; $display("FAIL flush_after: got full=%b en=%b ptr=%0d required 0 0 1", dut.stg_full_q, wb_en, dut.u_rr.ptr_q);
      end
      wb_ready = 1'b0; req[1] = 1'b1; res[1] = 32'h7777;
      tick();
      req[1] = 1'b0; req[2] = 1'b1; valid[2] = 1'b1;
      #1;
      tests++;
      if ({wb_en, wb_rd, dut.u_rr.ptr_q} !== {1'b1, 5'd6, 3'd2}) begin
         fails++; $display("FAIL pre_reset: got en=%b rd=%0d ptr=%0d required 1 6 2", wb_en, wb_rd, dut.u_rr.ptr_q);
      end
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({wb_en, exc_valid, wb_rd, wb_data, exc_src, alu_clear} !== '0) begin
         fails++; $display("FAIL async_reset: got en=%b exc=%b rd=%0d data=%h src=%0d clear=%b required all 0",
                           wb_en, exc_valid, wb_rd, wb_data, exc_src, alu_clear);
      end
      req = '0;
      tick();
      rst_n = 1'b1;
      #1;
      tests++;
      if (dut.u_rr.ptr_q !== 3'd0) begin
         fails++; $display("FAIL reset_ptr: got %0d required 0", dut.u_rr.ptr_q);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_x0();
      test_error_hold();
      test_flush_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_alu_commit_arbiter

`default_nettype wire
